inst_fetch: RTL and testbench

- Front-end fetch stage: owns the program counter and drives the synchronous-read instruction memory.
- Presents one instruction per cycle to the decode stage as inst, inst_enable, distinct, pc and pc1.
- Also handles downstream stalls through a one-entry hold register, and taken-branch redirects, including a redirect deferred behind a stall.

---
 rtl/inst_fetch.sv | 146 ++++++++++++++
 tb/tb_inst_fetch.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: front-end fetch stage.
// Owns the program counter, drives a synchronous-read instruction memory and
// presents one slot per cycle to decode. A one-entry hold register keeps the
// presented instruction stable across downstream stalls, and a pending-redirect
// register defers a branch that arrives while the stage is stalled.
//
// Handshake: inst_enable is a valid qualified by the inverse of stall (the
// ready). A slot is consumed only in a cycle where inst_enable=1; while
// stall=1 the slot (inst/pc/pc1/distinct) stays unchanged until accepted.
module inst_fetch #(
  parameter int INST_MEM_WIDTH = 2,
  parameter int START_PC       = 0
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      branch_valid,
  input  logic [INST_MEM_WIDTH-1:0] branch_target,
  output logic                      imem_en,
  output logic [INST_MEM_WIDTH-1:0] imem_addr,
  input  logic [31:0]               imem_rdata,
  output logic [31:0]               inst,
  output logic                      inst_enable,
  output logic                      distinct,
  output logic [INST_MEM_WIDTH-1:0] pc,
  output logic [INST_MEM_WIDTH-1:0] pc1,
  output logic                      dbg_state
);

  localparam int W = INST_MEM_WIDTH;
  localparam logic [W-1:0] START_ADDR = W'(START_PC);
  localparam logic [W-1:0] ONE        = W'(1);

  typedef enum logic {S_BOOT = 1'b0, S_RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  fpc_q, fpc_d;          // address issued to memory this cycle
  logic [W-1:0]  rpc_q, rpc_d;          // address of the presented slot
  logic          rvalid_q, rvalid_d;
  logic          rkill_q, rkill_d;      // presented slot is a wrong-path bubble
  logic [31:0]   hold_inst_q, hold_inst_d;
  logic          hold_valid_q, hold_valid_d;
  logic          pend_valid_q, pend_valid_d;
  logic [W-1:0]  pend_target_q, pend_target_d;

  assign dbg_state = state_q;

  // State register update with synchronous reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q       <= S_BOOT;
      fpc_q         <= START_ADDR;
      rpc_q         <= '0;
      rvalid_q      <= 1'b0;
      rkill_q       <= 1'b0;
      hold_inst_q   <= '0;
      hold_valid_q  <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      fpc_q         <= fpc_d;
      rpc_q         <= rpc_d;
      rvalid_q      <= rvalid_d;
      rkill_q       <= rkill_d;
      hold_inst_q   <= hold_inst_d;
      hold_valid_q  <= hold_valid_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  // Next-state and output decode for the boot/run sequencer.
  always_comb begin
    state_d       = state_q;
    fpc_d         = fpc_q;
    rpc_d         = rpc_q;
    rvalid_d      = rvalid_q;
    rkill_d       = rkill_q;
    hold_inst_d   = hold_inst_q;
    hold_valid_d  = hold_valid_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;

    imem_en     = 1'b0;
    imem_addr   = fpc_q;
    inst        = '0;
    inst_enable = 1'b0;
    distinct    = 1'b0;
    pc          = rpc_q;
    pc1         = rpc_q + ONE;

    if (reset) begin
      // Outputs are quiet while reset is held, whatever the current state.
      pc  = '0;
      pc1 = ONE;
    end else begin
      case (state_q)
        S_BOOT: begin
          // Issue the first fetch; its data becomes the first presented slot.
          imem_en  = 1'b1;
          rpc_d    = fpc_q;
          fpc_d    = fpc_q + ONE;
          rvalid_d = 1'b1;
          state_d  = S_RUN;
        end
        default: begin
          inst        = rkill_q ? 32'h0 : (hold_valid_q ? hold_inst_q : imem_rdata);
          distinct    = rkill_q;
          inst_enable = rvalid_q & ~stall;
          imem_en     = ~stall;
          if (!stall) begin
            rpc_d        = fpc_q;
            rvalid_d     = 1'b1;
            hold_valid_d = 1'b0;
            // Any advance retires the deferred redirect: a fresh branch in the
            // same cycle is younger and supersedes it.
            pend_valid_d = 1'b0;
            if (branch_valid) begin
              fpc_d   = branch_target;
              rkill_d = 1'b1;
            end else if (pend_valid_q) begin
              fpc_d   = pend_target_q;
              rkill_d = 1'b1;
            end else begin
              fpc_d   = fpc_q + ONE;
              rkill_d = 1'b0;
            end
          end else begin
            // Capture memory data on the first stall cycle, before it can change.
            if (rvalid_q && !hold_valid_q) begin
              hold_inst_d  = imem_rdata;
              hold_valid_d = 1'b1;
            end
            // Latest branch seen during a stall wins.
            if (branch_valid) begin
              pend_valid_d  = 1'b1;
              pend_target_d = branch_target;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: scenario tasks drive inst_fetch against a synchronous-read
// memory model; expected slots are queued up front and popped as the DUT
// presents them.
module tb_inst_fetch;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_valid;
  logic [1:0]  branch_target;
  logic        imem_en;
  logic [1:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_enable;
  logic        distinct;
  logic [1:0]  pc;
  logic [1:0]  pc1;
  logic        dbg_state;

  int checks = 0;
  int errors = 0;

  // Slot packing: {pc[1:0], pc1[1:0], distinct, inst[31:0]}
  logic [36:0] exp_q[$];

  // Values observed mid-cycle by the last call to cycle()
  logic        obs_en;
  logic [1:0]  obs_pc;
  logic [1:0]  obs_pc1;
  logic        obs_dist;
  logic [31:0] obs_inst;
  logic        obs_state;

  logic [31:0] mem [4];

  inst_fetch #(.INST_MEM_WIDTH(2), .START_PC(0)) dut (
    .CLK           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .imem_en       (imem_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .inst          (inst),
    .inst_enable   (inst_enable),
    .distinct      (distinct),
    .pc            (pc),
    .pc1           (pc1),
    .dbg_state     (dbg_state)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory; output is scrambled when not enabled so the
  // fetch stage cannot rely on it holding.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem[imem_addr];
    else         imem_rdata <= 32'hDEAD_0000 | $urandom_range(0, 16'hFFFF);
  end

  // Queue one expected slot
  task automatic push_slot(input logic [1:0] p, input logic kill);
    logic [1:0]  p1;
    logic [31:0] ei;
    p1 = p + 2'd1;
    ei = kill ? 32'h0 : (32'h1000_0000 | 32'(p));
    exp_q.push_back({p, p1, kill, ei});
  endtask

  // One clock cycle: drive inputs, observe mid-cycle, score any presented slot
  task automatic cycle(input logic rst, input logic st, input logic bv, input logic [1:0] bt);
    logic [36:0] e;
    reset = rst; stall = st; branch_valid = bv; branch_target = bt;
    #2;
    obs_en = inst_enable; obs_pc = pc; obs_pc1 = pc1;
    obs_dist = distinct; obs_inst = inst; obs_state = dbg_state;
    if (inst_enable === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_slot: got pc=%0d inst=%h, expected no slot", pc, inst);
      end else begin
        e = exp_q.pop_front();
        if ({pc, pc1, distinct, inst} !== e) begin
          errors++;
          $display("FAIL slot: got pc=%0d pc1=%0d distinct=%b inst=%h, expected pc=%0d pc1=%0d distinct=%b inst=%h",
                   pc, pc1, distinct, inst, e[36:35], e[34:33], e[32], e[31:0]);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  // Reset for one cycle, then the boot cycle that must present nothing
  task automatic reset_and_boot();
    exp_q.delete();
    cycle(1'b1, 1'b0, 1'b0, 2'd0);
    cycle(1'b0, 1'b0, 1'b0, 2'd0);
    checks++;
    if (obs_en !== 1'b0 || obs_state !== 1'b0) begin
      errors++;
      $display("FAIL boot_quiet: got en=%b state=%b, expected en=0 state=0", obs_en, obs_state);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: got %0d slots outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_stalled(input string name);
    checks++;
    if (obs_en !== 1'b0 || obs_pc !== 2'd1 || obs_inst !== 32'h1000_0001) begin
      errors++;
      $display("FAIL %s: got en=%b pc=%0d inst=%h, expected en=0 pc=1 inst=10000001",
               name, obs_en, obs_pc, obs_inst);
    end
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 1'b0, 2'd0);
    cycle(1'b1, 1'b1, 1'b1, 2'd3);
    checks++;
    if (obs_en !== 1'b0 || obs_dist !== 1'b0 || obs_inst !== 32'h0 || obs_pc !== 2'd0 || obs_pc1 !== 2'd1) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b dist=%b inst=%h pc=%0d pc1=%0d, expected 0 0 0 0 1",
               obs_en, obs_dist, obs_inst, obs_pc, obs_pc1);
    end
  endtask

  task automatic test_sequential();
    reset_and_boot();
    for (int i = 0; i < 6; i++) push_slot(2'(i), 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 2'd0);
    check_drained("sequential");
  endtask

  task automatic test_stall();
    reset_and_boot();
    for (int i = 0; i < 4; i++) push_slot(2'(i), 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 2'd0);
      check_stalled("stall_hold");
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 2'd0);
    check_drained("stall");
  endtask

  task automatic test_branch();
    reset_and_boot();
    push_slot(2'd0, 1'b0);
    push_slot(2'd1, 1'b1);
    push_slot(2'd3, 1'b0);
    push_slot(2'd0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 2'd3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 2'd0);
    check_drained("branch");
  endtask

  task automatic test_stall_branch();
    reset_and_boot();
    push_slot(2'd0, 1'b0);
    push_slot(2'd1, 1'b0);
    push_slot(2'd2, 1'b1);
    push_slot(2'd2, 1'b0);
    push_slot(2'd3, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 2'd0);
    cycle(1'b0, 1'b1, 1'b1, 2'd0);
    check_stalled("stall_branch_hold1");
    cycle(1'b0, 1'b1, 1'b1, 2'd2);
    check_stalled("stall_branch_hold2");
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 2'd0);
    check_drained("stall_branch");
  endtask

  task automatic test_reset_mid_stall();
    reset_and_boot();
    push_slot(2'd0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 2'd0);
    cycle(1'b0, 1'b1, 1'b1, 2'd3);
    cycle(1'b0, 1'b1, 1'b0, 2'd0);
    check_drained("pre_reset");
    cycle(1'b1, 1'b1, 1'b0, 2'd0);
    checks++;
    if (obs_en !== 1'b0 || obs_pc !== 2'd0 || obs_pc1 !== 2'd1 || obs_inst !== 32'h0) begin
      errors++;
      $display("FAIL mid_stall_reset_outputs: got en=%b pc=%0d pc1=%0d inst=%h, expected 0 0 1 0",
               obs_en, obs_pc, obs_pc1, obs_inst);
    end
    cycle(1'b0, 1'b0, 1'b0, 2'd0);
    checks++;
    if (obs_en !== 1'b0) begin
      errors++;
      $display("FAIL restart_boot_quiet: got en=%b, expected 0", obs_en);
    end
    for (int i = 0; i < 3; i++) push_slot(2'(i), 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 2'd0);
    check_drained("reset_mid_stall");
  endtask

  task automatic test_random_stall();
    int budget;
    logic st;
    reset_and_boot();
    for (int i = 0; i < 16; i++) push_slot(2'(i), 1'b0);
    budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      st = ($urandom_range(0, 2) == 0);
      cycle(1'b0, st, 1'b0, 2'd0);
      if (st) begin
        checks++;
        if (obs_en !== 1'b0) begin
          errors++;
          $display("FAIL random_stall_enable: got en=%b, expected 0", obs_en);
        end
      end
      budget++;
    end
    check_drained("random_stall");
  endtask

  // Test sequence and final report
  initial begin
    for (int i = 0; i < 4; i++) mem[i] = 32'h1000_0000 | 32'(i);
    reset = 1'b1; stall = 1'b0; branch_valid = 1'b0; branch_target = 2'd0;
    @(posedge clk); #1;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_stall_branch();
    test_reset_mid_stall();
    test_random_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
